// File: rtl/fmap_serializer.sv
// fmap_serializer: accepts a whole packed feature map through a valid/ready
// load handshake, then streams its elements out one per cycle in index order
// with index and last markers. A new map may be loaded on the last beat of
// the current one, so frames can follow each other with no bubble.
module fmap_serializer #(
  parameter int fm_width   = 5,
  parameter int fm_height  = 5,
  parameter int value_size = 16,
  localparam int N         = fm_width * fm_height,
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*value_size-1:0]   In_map,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [value_size-1:0]     out_data,
  output logic [IDX_W-1:0]          out_index,
  output logic                      out_last
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t state, next_state;
  logic [IDX_W-1:0] idx, idx_next;
  // Ascending element range so element 0 sits at the MSB end, matching In_map.
  logic [0:N-1][value_size-1:0] shadow;
  logic at_last;
  logic load;
  logic out_fire;

  // State, element counter and the captured map; the map only changes on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      shadow <= '0;
    end else begin
      state <= next_state;
      idx   <= idx_next;
      if (load) begin
        shadow <= In_map;
      end
    end
  end

  // Handshakes and next-state: a load is accepted when idle or on the final beat.
  always_comb begin
    at_last    = (idx == LAST_IDX);
    in_ready   = (state == IDLE) || ((state == SEND) && at_last && out_ready);
    load       = in_valid && in_ready;
    out_valid  = (state == SEND);
    out_fire   = out_valid && out_ready;
    next_state = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (load) begin
          next_state = SEND;
          idx_next   = '0;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (at_last) begin
            idx_next   = '0;
            next_state = load ? SEND : IDLE;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        next_state = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Element outputs come only from registered state and read zero while idle.
  always_comb begin
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (state == SEND) begin
      out_data  = shadow[idx];
      out_index = idx;
      out_last  = at_last;
    end
  end

endmodule

// File: tb/tb_fmap_serializer.sv
// tb_fmap_serializer: cycle-by-cycle vector table covering ordering,
// backpressure, back-to-back frames, busy-load rejection and sign
// pass-through, plus a hand-written asynchronous mid-frame reset sequence.
module tb_fmap_serializer;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int VS = 16;
  localparam int N  = W * H;
  localparam int IW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N*VS-1:0] In_map;
  logic            out_valid;
  logic            out_ready;
  logic [VS-1:0]   out_data;
  logic [IW-1:0]   out_index;
  logic            out_last;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          in_valid;
    int            map_sel;
    logic          out_ready;
    logic          exp_valid;
    logic          exp_ready;
    logic          exp_last;
    logic          chk_data;
    logic [VS-1:0] exp_data;
    logic [IW-1:0] exp_index;
  } vec_t;

  vec_t vecs[$];

  fmap_serializer #(.fm_width(W), .fm_height(H), .value_size(VS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In_map    (In_map),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Element i of each test map: 0 = A, 1 = B, 2 = all ones, 3 = sign pattern.
  function automatic logic [VS-1:0] elem(int kind, int i);
    logic [VS-1:0] v;
    case (kind)
      0:       v = 16'(32'h0001 + i);
      1:       v = 16'(32'hF000 + i);
      2:       v = 16'hFFFF;
      default: v = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
    endcase
    return v;
  endfunction

  function automatic logic [N*VS-1:0] make_map(int kind);
    logic [N*VS-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[(N-i)*VS-1 -: VS] = elem(kind, i);
    end
    return m;
  endfunction

  function automatic void add(logic iv, int sel, logic ordy, logic ev, logic erdy,
                              logic elast, logic chk, logic [VS-1:0] d, logic [IW-1:0] ix);
    vec_t v;
    v.in_valid  = iv;
    v.map_sel   = sel;
    v.out_ready = ordy;
    v.exp_valid = ev;
    v.exp_ready = erdy;
    v.exp_last  = elast;
    v.chk_data  = chk;
    v.exp_data  = d;
    v.exp_index = ix;
    vecs.push_back(v);
  endfunction

  function automatic void add_beat(int kind, int i, logic ordy, logic iv, int sel, logic erdy);
    add(iv, sel, ordy, 1'b1, erdy, (i == N-1), 1'b1, elem(kind, i), IW'(i));
  endfunction

  function automatic void add_idle();
    add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
  endfunction

  function automatic void add_load(int sel);
    add(1'b1, sel, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
  endfunction

  function automatic void add_plain_frame(int kind);
    add_load(kind);
    for (int i = 0; i < N; i++) add_beat(kind, i, 1'b1, 1'b0, 0, (i == N-1));
    add_idle();
  endfunction

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one vector at the falling edge and compare the outputs it should see.
  task automatic apply_stimulus(int k);
    vec_t v;
    v = vecs[k];
    @(negedge clk);
    in_valid  = v.in_valid;
    In_map    = make_map(v.map_sel);
    out_ready = v.out_ready;
    #1;
    check_output($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(v.exp_valid));
    check_output($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'(v.exp_ready));
    check_output($sformatf("vec%0d out_last", k), 32'(out_last), 32'(v.exp_last));
    if (v.exp_valid || v.chk_data) begin
      check_output($sformatf("vec%0d out_data", k), 32'(out_data), 32'(v.exp_data));
      check_output($sformatf("vec%0d out_index", k), 32'(out_index), 32'(v.exp_index));
    end
  endtask

  task automatic run_table();
    for (int k = 0; k < vecs.size(); k++) apply_stimulus(k);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    In_map    = '0;

    // Basic ordering, loaded straight out of reset with outputs still at reset values.
    add(1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < N; i++) add_beat(0, i, 1'b1, 1'b0, 0, (i == N-1));
    add_idle();

    // Backpressure: three stalled cycles at index 7 and at index 24.
    add_load(0);
    for (int i = 0; i < N; i++) begin
      if (i == 7 || i == N-1) begin
        for (int s = 0; s < 3; s++) add_beat(0, i, 1'b0, 1'b0, 0, 1'b0);
      end
      add_beat(0, i, 1'b1, 1'b0, 0, (i == N-1));
    end
    add_idle();

    // Back-to-back: B is offered and taken on A's last beat, no bubble.
    add_load(0);
    for (int i = 0; i < N; i++) add_beat(0, i, 1'b1, (i == N-1), 1, (i == N-1));
    for (int i = 0; i < N; i++) add_beat(1, i, 1'b1, 1'b0, 0, (i == N-1));
    add_idle();

    // Busy-load: all-ones map held on in_valid, ignored until A's last beat.
    add_load(0);
    for (int i = 0; i < N; i++) add_beat(0, i, 1'b1, 1'b1, 2, (i == N-1));
    for (int i = 0; i < N; i++) add_beat(2, i, 1'b1, 1'b0, 0, (i == N-1));
    add_idle();

    // Sign pass-through.
    add_plain_frame(3);

    #1;
    check_output("reset out_valid", 32'(out_valid), 32'd0);
    check_output("reset out_last", 32'(out_last), 32'd0);
    check_output("reset out_index", 32'(out_index), 32'd0);
    check_output("reset out_data", 32'(out_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("post-reset in_ready", 32'(in_ready), 32'd1);

    run_table();

    // Mid-frame reset: walk to index 12, then pull rst_n low between edges.
    vecs.delete();
    add_load(0);
    for (int i = 0; i < 12; i++) add_beat(0, i, 1'b1, 1'b0, 0, 1'b0);
    run_table();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_output("pre-reset out_index", 32'(out_index), 32'd12);
    check_output("pre-reset out_data", 32'(out_data), 32'h000D);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("async reset out_valid", 32'(out_valid), 32'd0);
    check_output("async reset out_last", 32'(out_last), 32'd0);
    check_output("async reset out_index", 32'(out_index), 32'd0);
    check_output("async reset out_data", 32'(out_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("after release out_valid", 32'(out_valid), 32'd0);
    check_output("after release in_ready", 32'(in_ready), 32'd1);

    // The next frame must start fresh at index 0.
    vecs.delete();
    add_plain_frame(0);
    run_table();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
